// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter slice.
package mem_arb_pkg;

    localparam int MAX_WAIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } arb_state_t;

    typedef enum logic [1:0] {
        P_IF,
        P_D,
        P_DBG
    } port_id_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating fetch-starvation counter: counts RUN cycles in which fetch asks but loses,
// and flags expiry so fetch can pre-empt the data port.
module arb_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic run,
    input  logic if_req,
    input  logic if_gnt,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;

    // Outside RUN the count is frozen so a halt does not forgive or punish fetch.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wait_cnt <= '0;
        end else if (run) begin
            if (!if_req || if_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign expired = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch, data and debug ports, with bounded fetch starvation
// and a halt/drain handshake that hands the RAM exclusively to debug.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          dbg_halt,
    output logic          dbg_halted,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t state, next_state;
    logic       wait_expired;
    logic       read_gnt;
    port_id_t   read_port;
    logic       tag_valid;
    port_id_t   tag_port;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .run     (state == ST_RUN),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .expired (wait_expired)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Halt request in RUN suppresses core grants at once; DRAIN lets the last core read return.
    always_comb begin
        next_state = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        dbg_gnt    = 1'b0;
        case (state)
            ST_RUN: begin
                if (dbg_halt) begin
                    next_state = ST_DRAIN;
                end else if (if_req && (wait_expired || !d_req)) begin
                    if_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
            end
            ST_DRAIN: begin
                next_state = dbg_halt ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: begin
                dbg_gnt = dbg_req;
                if (!dbg_halt) begin
                    next_state = ST_RUN;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        read_gnt  = 1'b0;
        read_port = P_IF;
        if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            read_gnt  = 1'b1;
            read_port = P_IF;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            read_gnt  = !d_we;
            read_port = P_D;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            read_gnt  = !dbg_we;
            read_port = P_DBG;
        end
    end

    // The tag remembers who owns the RAM output next cycle; it is rewritten every cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tag_valid <= 1'b0;
            tag_port  <= P_IF;
        end else begin
            tag_valid <= read_gnt;
            tag_port  <= read_port;
        end
    end

    assign if_rvalid  = tag_valid && (tag_port == P_IF);
    assign d_rvalid   = tag_valid && (tag_port == P_D);
    assign dbg_rvalid = tag_valid && (tag_port == P_DBG);

    assign if_rdata   = if_rvalid  ? mem_rdata : '0;
    assign d_rdata    = d_rvalid   ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    assign dbg_halted = (state == ST_HALTED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized RUN-mode
// traffic checked against a behavioural arbitration/memory model.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          dbg_halt, dbg_halted;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    bit [DW-1:0] ram    [0:(1<<AW)-1];
    bit [DW-1:0] shadow [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .dbg_halt(dbg_halt), .dbg_halted(dbg_halted),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment RAM: one-cycle read latency, output holds between reads.
    always @(posedge CLK) begin
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    end

    task automatic set_idle();
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        dbg_halt = 0; dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic next_cycle();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RSTn = 0;
        set_idle();
        next_cycle();
        next_cycle();
        #1;
        total++;
        if ({if_gnt, d_gnt, dbg_gnt, if_rvalid, d_rvalid, dbg_rvalid, dbg_halted, mem_en, mem_we} !== 9'b0
            || mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0 || dbg_rdata !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: gnts=%b%b%b rv=%b%b%b halted=%b mem_en=%b addr=%h required all 0",
                     if_gnt, d_gnt, dbg_gnt, if_rvalid, d_rvalid, dbg_rvalid, dbg_halted, mem_en, mem_addr);
        end
        next_cycle();
        RSTn = 1;
        next_cycle();
    endtask

    task automatic test_data_write();
        d_req = 1; d_we = 1; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
        #1;
        total++;
        if (d_gnt !== 1 || mem_en !== 1 || mem_we !== 1 || mem_addr !== 10'h010 || mem_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL write_bus: d_gnt=%b en=%b we=%b addr=%h wdata=%h required 1 1 1 010 deadbeef",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        shadow[10'h010] = 32'hDEADBEEF;
        next_cycle();
        d_addr = 10'h004; d_wdata = 32'h00500093;
        #1;
        total++;
        if (d_rvalid !== 0 || d_rdata !== '0 || d_gnt !== 1) begin
            bad++;
            $display("[TB] FAIL write_no_rvalid: d_rvalid=%b d_rdata=%h d_gnt=%b required 0 0 1",
                     d_rvalid, d_rdata, d_gnt);
        end
        shadow[10'h004] = 32'h00500093;
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_fetch_read();
        if_req = 1; if_addr = 10'h004;
        #1;
        total++;
        if (if_gnt !== 1 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 10'h004) begin
            bad++;
            $display("[TB] FAIL fetch_grant: if_gnt=%b en=%b we=%b addr=%h required 1 1 0 004",
                     if_gnt, mem_en, mem_we, mem_addr);
        end
        next_cycle();
        set_idle();
        #1;
        total++;
        if (if_rvalid !== 1 || if_rdata !== shadow[10'h004] || d_rvalid !== 0 || d_rdata !== '0) begin
            bad++;
            $display("[TB] FAIL fetch_rdata: if_rvalid=%b if_rdata=%h d_rvalid=%b required 1 %h 0",
                     if_rvalid, if_rdata, d_rvalid, shadow[10'h004]);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [5:0] got_if, got_d;
        if_req = 1; if_addr = 10'h004;
        d_req = 1; d_we = 0; d_addr = 10'h010;
        for (int c = 0; c < 6; c++) begin
            #1;
            got_if[c] = if_gnt;
            got_d[c]  = d_gnt;
            next_cycle();
        end
        total++;
        if (got_if !== 6'b010000 || got_d !== 6'b101111) begin
            bad++;
            $display("[TB] FAIL starvation_order: if_gnt=%b d_gnt=%b (cycle6..1) required 010000 101111",
                     got_if, got_d);
        end
        set_idle();
        next_cycle();
    endtask

    task automatic test_halt_drain();
        logic any_core_gnt;
        if_req = 1; if_addr = 10'h010;
        #1;
        total++;
        if (if_gnt !== 1) begin
            bad++;
            $display("[TB] FAIL halt_pre_grant: if_gnt=%b required 1", if_gnt);
        end
        next_cycle();
        d_req = 1; d_we = 0; d_addr = 10'h004;
        dbg_halt = 1;
        #1;
        total++;
        if (if_gnt !== 0 || d_gnt !== 0 || dbg_gnt !== 0 || if_rvalid !== 1 || if_rdata !== shadow[10'h010]) begin
            bad++;
            $display("[TB] FAIL halt_first_cycle: gnts=%b%b%b if_rvalid=%b if_rdata=%h required 000 1 %h",
                     if_gnt, d_gnt, dbg_gnt, if_rvalid, if_rdata, shadow[10'h010]);
        end
        next_cycle();
        #1;
        total++;
        if (if_gnt !== 0 || d_gnt !== 0 || dbg_halted !== 0 || if_rvalid !== 0) begin
            bad++;
            $display("[TB] FAIL drain_cycle: if_gnt=%b d_gnt=%b halted=%b if_rvalid=%b required 0 0 0 0",
                     if_gnt, d_gnt, dbg_halted, if_rvalid);
        end
        any_core_gnt = 0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            #1;
            any_core_gnt = any_core_gnt | if_gnt | d_gnt;
            total++;
            if (dbg_halted !== 1) begin
                bad++;
                $display("[TB] FAIL halted_flag: dbg_halted=%b required 1 (cycle %0d)", dbg_halted, c);
            end
        end
        total++;
        if (any_core_gnt !== 0) begin
            bad++;
            $display("[TB] FAIL halted_core_blocked: core grant seen=%b required 0", any_core_gnt);
        end
        next_cycle();
    endtask

    task automatic test_debug_access();
        d_req = 0;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h3FF; dbg_wdata = 32'h12345678;
        #1;
        total++;
        if (dbg_gnt !== 1 || mem_en !== 1 || mem_we !== 1 || mem_addr !== 10'h3FF || mem_wdata !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL dbg_write_bus: dbg_gnt=%b en=%b we=%b addr=%h wdata=%h required 1 1 1 3ff 12345678",
                     dbg_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        shadow[10'h3FF] = 32'h12345678;
        next_cycle();
        dbg_we = 0; dbg_wdata = '0;
        #1;
        total++;
        if (dbg_gnt !== 1 || mem_we !== 0 || dbg_rvalid !== 0) begin
            bad++;
            $display("[TB] FAIL dbg_read_grant: dbg_gnt=%b we=%b dbg_rvalid=%b required 1 0 0",
                     dbg_gnt, mem_we, dbg_rvalid);
        end
        next_cycle();
        dbg_req = 0;
        dbg_halt = 0;
        #1;
        total++;
        if (dbg_rvalid !== 1 || dbg_rdata !== 32'h12345678 || if_gnt !== 0) begin
            bad++;
            $display("[TB] FAIL dbg_read_data: dbg_rvalid=%b dbg_rdata=%h if_gnt=%b required 1 12345678 0",
                     dbg_rvalid, dbg_rdata, if_gnt);
        end
        next_cycle();
        #1;
        total++;
        if (dbg_halted !== 0 || if_gnt !== 1 || dbg_rvalid !== 0) begin
            bad++;
            $display("[TB] FAIL resume_run: dbg_halted=%b if_gnt=%b dbg_rvalid=%b required 0 1 0",
                     dbg_halted, if_gnt, dbg_rvalid);
        end
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_access();
        logic seen_rvalid;
        d_req = 1; d_we = 0; d_addr = 10'h010;
        #1;
        total++;
        if (d_gnt !== 1) begin
            bad++;
            $display("[TB] FAIL rst_pre_grant: d_gnt=%b required 1", d_gnt);
        end
        #1;
        RSTn = 0;
        seen_rvalid = 0;
        set_idle();
        for (int c = 0; c < 6; c++) begin
            #1;
            seen_rvalid = seen_rvalid | d_rvalid;
        end
        next_cycle();
        #1;
        seen_rvalid = seen_rvalid | d_rvalid;
        RSTn = 1;
        next_cycle();
        #1;
        seen_rvalid = seen_rvalid | d_rvalid;
        total++;
        if (seen_rvalid !== 0) begin
            bad++;
            $display("[TB] FAIL rst_drops_response: d_rvalid seen=%b required 0", seen_rvalid);
        end
        total++;
        if ({if_gnt, d_gnt, dbg_gnt, if_rvalid, d_rvalid, dbg_rvalid, dbg_halted, mem_en, mem_we} !== 9'b0
            || mem_addr !== '0 || d_rdata !== '0) begin
            bad++;
            $display("[TB] FAIL rst_release_outputs: gnts=%b%b%b rv=%b%b%b halted=%b en=%b required all 0",
                     if_gnt, d_gnt, dbg_gnt, if_rvalid, d_rvalid, dbg_rvalid, dbg_halted, mem_en);
        end
        if_req = 1; if_addr = 10'h004;
        #1;
        total++;
        if (if_gnt !== 1) begin
            bad++;
            $display("[TB] FAIL rst_back_in_run: if_gnt=%b required 1", if_gnt);
        end
        next_cycle();
        set_idle();
        next_cycle();
    endtask

    // Model view: fetch is owed the RAM once it has lost MAX_WAIT straight cycles; otherwise
    // data has priority. The RAM is tracked as an array updated by the writes we expect to issue.
    task automatic test_random_run();
        int starve = 0;
        bit exp_rv_if = 0, exp_rv_d = 0;
        bit [DW-1:0] exp_rv_data = '0;
        bit e_if, e_d, e_en, e_we;
        bit [AW-1:0] e_addr;
        bit [DW-1:0] e_wdata;
        for (int c = 0; c < 400; c++) begin
            if_req    = 1'($urandom);
            if_addr   = AW'($urandom_range(0, 15));
            d_req     = 1'($urandom);
            d_we      = 1'($urandom);
            d_addr    = AW'($urandom_range(0, 15));
            d_wdata   = $urandom;
            dbg_req   = 1'($urandom);
            dbg_we    = 1'($urandom);
            dbg_addr  = AW'($urandom_range(0, 15));
            dbg_wdata = $urandom;
            e_if = if_req && (starve >= MAX_WAIT || !d_req);
            e_d  = d_req && !e_if;
            e_en = e_if || e_d;
            e_we = e_d && d_we;
            e_addr  = e_if ? if_addr : (e_d ? d_addr : '0);
            e_wdata = e_d ? d_wdata : '0;
            #1;
            total++;
            if (if_gnt !== e_if || d_gnt !== e_d || dbg_gnt !== 0) begin
                bad++;
                $display("[TB] FAIL rand_grant c=%0d: gnt if/d/dbg=%b%b%b required %b%b0",
                         c, if_gnt, d_gnt, dbg_gnt, e_if, e_d);
            end
            total++;
            if (mem_en !== e_en || mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                bad++;
                $display("[TB] FAIL rand_mem c=%0d: en=%b we=%b addr=%h wdata=%h required %b %b %h %h",
                         c, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_addr, e_wdata);
            end
            total++;
            if (if_rvalid !== exp_rv_if || d_rvalid !== exp_rv_d || dbg_rvalid !== 0
                || if_rdata !== (exp_rv_if ? exp_rv_data : '0) || d_rdata !== (exp_rv_d ? exp_rv_data : '0)) begin
                bad++;
                $display("[TB] FAIL rand_resp c=%0d: rv if/d=%b%b if_rdata=%h d_rdata=%h required %b%b data=%h",
                         c, if_rvalid, d_rvalid, if_rdata, d_rdata, exp_rv_if, exp_rv_d, exp_rv_data);
            end
            exp_rv_if = e_if;
            exp_rv_d  = e_d && !d_we;
            exp_rv_data = e_if ? shadow[if_addr] : shadow[d_addr];
            if (e_d && d_we) shadow[d_addr] = d_wdata;
            if (if_req && !e_if) starve = (starve < MAX_WAIT) ? starve + 1 : MAX_WAIT;
            else starve = 0;
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_data_write();
        test_fetch_read();
        test_starvation();
        test_halt_drain();
        test_debug_access();
        test_reset_mid_access();
        test_random_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
